// File: rtl/div_ctrl.sv
// Multi-cycle divide sequencer between the EX stage and an iterative divider.
// Optional feature: define DIV_ZERO_FAST_EN to retire zero-divisor divides without starting the divider.
module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_aluop,
    input  logic [31:0] i_reg1_data,
    input  logic [31:0] i_reg2_data,
    input  logic        i_flush,
    input  logic        i_ex_stall,
    input  logic [63:0] i_div_result,
    input  logic        i_div_ready,
    output logic [31:0] o_div_opdata1,
    output logic [31:0] o_div_opdata2,
    output logic        o_div_signed,
    output logic        o_div_start,
    output logic        o_div_annul,
    output logic        o_stallreq,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_whilo
);

    localparam int unsigned DW = 32;
    localparam logic [7:0] ALU_DIV  = 8'b00011010;
    localparam logic [7:0] ALU_DIVU = 8'b00011011;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state;
    state_t         state_nx;
    logic           div_op_c;
    logic           zero_div_c;
    logic           stallreq_c;
    logic           annul_c;
    logic           load_ops_c;
    logic           capture_c;
    logic           fast_zero_c;
    logic           whilo_q;
    logic [DW-1:0]  hi_q;
    logic [DW-1:0]  lo_q;

    assign div_op_c = ((i_aluop == ALU_DIV) || (i_aluop == ALU_DIVU)) && !i_flush;

`ifdef DIV_ZERO_FAST_EN
    assign zero_div_c = (i_reg2_data == '0);
`else
    assign zero_div_c = 1'b0;
`endif

    // Next-state and per-cycle control strobes
    always_comb begin
        state_nx    = state;
        stallreq_c  = 1'b0;
        annul_c     = 1'b0;
        load_ops_c  = 1'b0;
        capture_c   = 1'b0;
        fast_zero_c = 1'b0;
        case (state)
            IDLE: begin
                if (div_op_c) begin
                    stallreq_c = 1'b1;
                    load_ops_c = 1'b1;
                    if (zero_div_c) begin
                        fast_zero_c = 1'b1;
                        state_nx    = DONE;
                    end else begin
                        state_nx = BUSY;
                    end
                end
            end
            BUSY: begin
                stallreq_c = 1'b1;
                if (i_flush) begin
                    annul_c  = 1'b1;
                    state_nx = IDLE;
                end else if (i_div_ready) begin
                    capture_c = 1'b1;
                    state_nx  = DONE;
                end
            end
            DONE: begin
                // Hold the HI/LO write until EX is free to retire the instruction
                if (i_flush || !i_ex_stall) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            o_div_start   <= 1'b0;
            o_div_signed  <= 1'b0;
            o_div_opdata1 <= '0;
            o_div_opdata2 <= '0;
            whilo_q       <= 1'b0;
            hi_q          <= '0;
            lo_q          <= '0;
        end else begin
            state       <= state_nx;
            o_div_start <= (state_nx == BUSY);
            whilo_q     <= (state_nx == DONE);
            if (load_ops_c) begin
                o_div_opdata1 <= i_reg1_data;
                o_div_opdata2 <= i_reg2_data;
                o_div_signed  <= (i_aluop == ALU_DIV);
            end
            if (capture_c) begin
                hi_q <= i_div_result[63:32];
                lo_q <= i_div_result[31:0];
            end else if (fast_zero_c) begin
                hi_q <= '0;
                lo_q <= '0;
            end
        end
    end

    // A flush or reset in DONE must suppress the write in the same cycle
    assign o_whilo     = whilo_q && !i_flush && !rst;
    assign o_stallreq  = stallreq_c;
    assign o_div_annul = annul_c;
    assign o_hi        = hi_q;
    assign o_lo        = lo_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Randomized self-checking bench for div_ctrl with a transaction-level divide model.
// Build with DIV_ZERO_FAST_EN defined to exercise the zero-divisor shortcut.
module tb_div_ctrl;

    localparam logic [7:0] OP_DIV  = 8'h1A;
    localparam logic [7:0] OP_DIVU = 8'h1B;
    localparam logic [7:0] OP_NOP  = 8'h00;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  i_aluop;
    logic [31:0] i_reg1_data, i_reg2_data;
    logic        i_flush, i_ex_stall;
    logic [63:0] i_div_result;
    logic        i_div_ready;
    logic [31:0] o_div_opdata1, o_div_opdata2;
    logic        o_div_signed, o_div_start, o_div_annul, o_stallreq;
    logic [31:0] o_hi, o_lo;
    logic        o_whilo;

    always #5 clk = ~clk;

    div_ctrl dut (
        .clk(clk), .rst(rst), .i_aluop(i_aluop),
        .i_reg1_data(i_reg1_data), .i_reg2_data(i_reg2_data),
        .i_flush(i_flush), .i_ex_stall(i_ex_stall),
        .i_div_result(i_div_result), .i_div_ready(i_div_ready),
        .o_div_opdata1(o_div_opdata1), .o_div_opdata2(o_div_opdata2),
        .o_div_signed(o_div_signed), .o_div_start(o_div_start),
        .o_div_annul(o_div_annul), .o_stallreq(o_stallreq),
        .o_hi(o_hi), .o_lo(o_lo), .o_whilo(o_whilo)
    );

    // Reference: where the divide instruction is in its life, plus architectural results
    typedef enum int {PH_IDLE, PH_BUSY, PH_DONE} ph_t;
    ph_t         m_ph;
    logic [31:0] m_op1, m_op2, m_hi, m_lo;
    logic        m_signed;
    int          m_cnt, m_lat, lat_cfg;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;
    int n_stall, n_whilo, n_start, n_annul;

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        int sq, sr;
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            sq = $signed(a) / $signed(b);
            sr = $signed(a) % $signed(b);
            return {32'(sr), 32'(sq)};
        end
        return {a % b, a / b};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit zero_fast(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
        return (b == 32'h0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_outputs();
        bit div_op;
        div_op = ((i_aluop == OP_DIV) || (i_aluop == OP_DIVU)) && !i_flush;
        chk("stallreq", 64'(o_stallreq), 64'((m_ph == PH_IDLE && div_op) || m_ph == PH_BUSY));
        chk("annul",    64'(o_div_annul), 64'(m_ph == PH_BUSY && i_flush));
        chk("start",    64'(o_div_start), 64'(m_ph == PH_BUSY));
        chk("whilo",    64'(o_whilo), 64'(m_ph == PH_DONE && !i_flush && !rst));
        chk("opdata1",  64'(o_div_opdata1), 64'(m_op1));
        chk("opdata2",  64'(o_div_opdata2), 64'(m_op2));
        chk("signed",   64'(o_div_signed), 64'(m_signed));
        chk("hi",       64'(o_hi), 64'(m_hi));
        chk("lo",       64'(o_lo), 64'(m_lo));
    endtask

    task automatic model_step();
        logic [63:0] res;
        if (rst) begin
            m_ph = PH_IDLE; m_op1 = '0; m_op2 = '0; m_signed = 1'b0; m_hi = '0; m_lo = '0;
            return;
        end
        case (m_ph)
            PH_IDLE: if (((i_aluop == OP_DIV) || (i_aluop == OP_DIVU)) && !i_flush) begin
                m_op1 = i_reg1_data; m_op2 = i_reg2_data; m_signed = (i_aluop == OP_DIV);
                m_cnt = 0;
                m_lat = (lat_cfg != 0) ? lat_cfg : ($urandom_range(0, 3) == 0 ? 32 : int'($urandom_range(1, 40)));
                if (zero_fast(i_reg2_data)) begin
                    m_hi = '0; m_lo = '0; m_ph = PH_DONE;
                end else begin
                    m_ph = PH_BUSY;
                end
            end
            PH_BUSY: begin
                if (i_flush) m_ph = PH_IDLE;
                else if (i_div_ready) begin
                    res = i_div_result;
                    m_hi = res[63:32]; m_lo = res[31:0]; m_ph = PH_DONE;
                end else m_cnt++;
            end
            default: if (i_flush || !i_ex_stall) m_ph = PH_IDLE;
        endcase
    endtask

    // One clock: drive at negedge, check, then advance the model to the coming edge
    task automatic cycle(input logic r, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic fl, input logic st);
        @(negedge clk);
        rst = r; i_aluop = op; i_reg1_data = a; i_reg2_data = b; i_flush = fl; i_ex_stall = st;
        i_div_ready  = (m_ph == PH_BUSY) && (m_cnt + 1 >= m_lat);
        i_div_result = ref_div(m_op1, m_op2, m_signed);
        #1;
        if (chk_en) check_outputs();
        if (o_stallreq)  n_stall++;
        if (o_whilo)     n_whilo++;
        if (o_div_start) n_start++;
        if (o_div_annul) n_annul++;
        model_step();
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, OP_NOP, $urandom, $urandom, 1'b0, 1'b0);
    endtask

    task automatic clr_counts();
        n_stall = 0; n_whilo = 0; n_start = 0; n_annul = 0;
    endtask

    initial begin
        rst = 1'b1; i_aluop = OP_NOP; i_reg1_data = '0; i_reg2_data = '0;
        i_flush = 1'b0; i_ex_stall = 1'b0; i_div_result = '0; i_div_ready = 1'b0;
        m_ph = PH_IDLE; m_cnt = 0; m_lat = 1; lat_cfg = 0;
        m_op1 = '0; m_op2 = '0; m_hi = '0; m_lo = '0; m_signed = 1'b0;
        clr_counts();

        cycle(1'b1, OP_NOP, '0, '0, 1'b0, 1'b0);
        chk_en = 1'b1;
        cycle(1'b1, OP_NOP, '0, '0, 1'b0, 1'b0);
        nop(1);
        chk("reset_hi", 64'(o_hi), 64'h0);
        chk("reset_start", 64'(o_div_start), 64'h0);

        // DIVU 100 / 7 with a 32-cycle divider
        lat_cfg = 32; clr_counts();
        cycle(1'b0, OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
        nop(36);
        chk("divu_stall_cycles", 64'(n_stall), 64'd33);
        chk("divu_whilo_cycles", 64'(n_whilo), 64'd1);
        chk("divu_hi", 64'(o_hi), 64'd2);
        chk("divu_lo", 64'(o_lo), 64'd14);

        // Signed DIV -7 / 2
        lat_cfg = 5;
        cycle(1'b0, OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        nop(1);
        chk("div_signed_flag", 64'(o_div_signed), 64'h1);
        nop(8);
        chk("div_lo", 64'(o_lo), 64'hFFFF_FFFD);
        chk("div_hi", 64'(o_hi), 64'hFFFF_FFFF);

        // Flush in the tenth BUSY cycle
        lat_cfg = 40; clr_counts();
        cycle(1'b0, OP_DIVU, 32'd1000, 32'd3, 1'b0, 1'b0);
        nop(9);
        cycle(1'b0, OP_NOP, '0, '0, 1'b1, 1'b0);
        chk("flush_annul", 64'(o_div_annul), 64'h1);
        nop(1);
        chk("flush_start", 64'(o_div_start), 64'h0);
        nop(5);
        chk("flush_whilo_count", 64'(n_whilo), 64'h0);
        chk("flush_annul_count", 64'(n_annul), 64'h1);

        // EX stall holds the HI/LO write for four cycles
        lat_cfg = 3;
        cycle(1'b0, OP_DIVU, 32'd50, 32'd6, 1'b0, 1'b0);
        nop(3);
        clr_counts();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, OP_NOP, '0, '0, 1'b0, (i < 3) ? 1'b1 : 1'b0);
            chk("hold_hi", 64'(o_hi), 64'd2);
            chk("hold_lo", 64'(o_lo), 64'd8);
        end
        chk("hold_whilo_count", 64'(n_whilo), 64'd4);
        chk("hold_start_count", 64'(n_start), 64'd0);
        nop(2);

        // Zero divisor
        lat_cfg = 4; clr_counts();
        cycle(1'b0, OP_DIVU, 32'd77, 32'd0, 1'b0, 1'b0);
        nop(8);
`ifdef DIV_ZERO_FAST_EN
        chk("zero_start_count", 64'(n_start), 64'd0);
        chk("zero_stall_count", 64'(n_stall), 64'd1);
        chk("zero_hi", 64'(o_hi), 64'd0);
        chk("zero_lo", 64'(o_lo), 64'd0);
`else
        chk("zero_start_count", 64'(n_start), 64'd4);
        chk("zero_stall_count", 64'(n_stall), 64'd5);
        chk("zero_hi", 64'(o_hi), 64'd77);
        chk("zero_lo", 64'(o_lo), 64'hFFFF_FFFF);
`endif
        chk("zero_whilo_count", 64'(n_whilo), 64'd1);

        // Reset mid-BUSY, then a clean DIVU 9 / 3
        lat_cfg = 20;
        cycle(1'b0, OP_DIV, 32'd12345, 32'd11, 1'b0, 1'b0);
        nop(5);
        cycle(1'b1, OP_NOP, '0, '0, 1'b0, 1'b0);
        nop(1);
        chk("rst_start", 64'(o_div_start), 64'h0);
        chk("rst_op1", 64'(o_div_opdata1), 64'h0);
        chk("rst_lo", 64'(o_lo), 64'h0);
        chk("rst_signed", 64'(o_div_signed), 64'h0);
        lat_cfg = 6;
        cycle(1'b0, OP_DIVU, 32'd9, 32'd3, 1'b0, 1'b0);
        nop(10);
        chk("post_rst_lo", 64'(o_lo), 64'd3);
        chk("post_rst_hi", 64'(o_hi), 64'd0);

        // Randomized traffic against the model
        lat_cfg = 0;
        for (int k = 0; k < 4000; k++) begin
            logic        r, fl, st;
            logic [7:0]  op;
            logic [31:0] a, b;
            r = ($urandom_range(0, 99) == 0);
            case ($urandom_range(0, 4))
                0, 1:    op = OP_DIV;
                2, 3:    op = OP_DIVU;
                default: op = 8'($urandom);
            endcase
            if (r) op = OP_NOP;
            a  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 200)) : 32'($urandom);
            b  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : 32'($urandom);
            if ($urandom_range(0, 9) == 0) b = 32'h0;
            fl = ($urandom_range(0, 29) == 0);
            st = ($urandom_range(0, 2) == 0);
            cycle(r, op, a, b, fl, st);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous active-high reset.
REQ-003 SHALL have ports: i_aluop  in  8  EX ALU opcode; DIV = 8'b00011010, DIVU = 8'b00011011.
REQ-004 SHALL have ports: i_reg1_data  in  32  dividend; i_reg2_data  in  32  divisor.
REQ-005 SHALL have ports: i_flush  in  1  pipeline flush / exception kill; i_ex_stall  in  1  stall of EX by a later stage.
REQ-006 SHALL have ports: i_div_result  in  64  divider result {remainder, quotient}; i_div_ready  in  1  divider done.
REQ-007 SHALL have ports: o_div_opdata1, o_div_opdata2  out  32  latched operands; o_div_signed  out  1; o_div_start  out  1; o_div_annul  out  1.
REQ-008 SHALL have ports: o_stallreq  out  1  stall request to pipeline control; o_hi, o_lo  out  32; o_whilo  out  1  HI/LO write enable.

Function
REQ-009 SHALL implement FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-010 IDLE: div op = (i_aluop is DIV or DIVU) and !i_flush; on div op, latch operands, o_div_signed = (i_aluop == DIV), go BUSY next edge.
REQ-011 o_stallreq SHALL be combinational: 1 when (IDLE and div op) or BUSY; 0 in DONE and in IDLE without div op.
REQ-012 o_div_start, o_div_opdata1/2, o_div_signed SHALL be registered; o_div_start = 1 for every BUSY cycle and 0 elsewhere.
REQ-013 BUSY with i_div_ready = 1 and !i_flush: capture o_hi = i_div_result[63:32], o_lo = i_div_result[31:0], drop o_div_start, go DONE.
REQ-014 DONE: o_whilo = 1; if i_ex_stall = 1 remain DONE (o_hi/o_lo/o_whilo held, no reissue); else go IDLE.
REQ-015 o_whilo SHALL be 0 in IDLE and BUSY; o_hi/o_lo hold last captured value outside capture.
REQ-016 Flush in BUSY: o_div_annul = 1 combinationally that cycle, go IDLE, o_div_start = 0 next cycle, no HI/LO capture even if i_div_ready = 1 same cycle.
REQ-017 Flush in DONE: o_whilo forced 0 that cycle, go IDLE. Flush in IDLE: no issue, no stall.
REQ-018 o_div_annul SHALL be 0 in all states except BUSY with i_flush = 1.
REQ-019 Stall cycles for one divide = 1 (IDLE issue) + number of BUSY cycles; the instruction leaves EX at the end of the first DONE cycle with i_ex_stall = 0.
REQ-020 Operand registers SHALL not change while BUSY or DONE, regardless of i_reg1_data/i_reg2_data.

Reset
REQ-021 On rst = 1 at a clock edge: state IDLE; o_div_start, o_div_signed, o_whilo = 0; o_div_opdata1/2, o_hi, o_lo = 0.
REQ-022 Reset mid-BUSY or mid-DONE SHALL abandon the operation with no o_whilo pulse; o_div_annul stays 0 (divider is reset by the same rst).

Configuration
REQ-023 Macro DIV_ZERO_FAST_EN: when defined, IDLE div op with i_reg2_data == 0 SHALL go directly to DONE, load o_hi = o_lo = 0, never assert o_div_start, and assert o_stallreq only in the IDLE cycle.
REQ-024 Without DIV_ZERO_FAST_EN, zero divisors SHALL take the normal BUSY path and the divider result is used unmodified.

Verification
REQ-025 DIVU 100 / 7, divider ready after 32 BUSY cycles -> o_stallreq high 33 cycles, DONE with o_hi = 2, o_lo = 14, o_whilo = 1 for one cycle.
REQ-026 DIV 0xFFFFFFF9 / 2 -> o_div_signed = 1, result o_lo = 0xFFFFFFFD, o_hi = 0xFFFFFFFF.
REQ-027 i_flush in 10th BUSY cycle -> o_div_annul = 1 that cycle, IDLE next, o_div_start 0, o_whilo never asserted.
REQ-028 i_ex_stall = 1 for 3 cycles entering DONE -> o_whilo held 4 cycles with constant o_hi/o_lo, o_div_start stays 0.
REQ-029 DIVU x / 0 with DIV_ZERO_FAST_EN -> DONE next cycle, o_hi = o_lo = 0, o_div_start never 1; without macro -> normal BUSY path.
REQ-030 rst asserted mid-BUSY -> all outputs at reset values next cycle; subsequent DIVU 9 / 3 completes with o_lo = 3, o_hi = 0.
